ashifter_32bit: RTL and testbench
=================================

// Module: ashifter_32bit
// PURPOSE
//   32-bit single-position arithmetic shifter used in the ALU logic group.
//   C selects direction: 0 = arithmetic shift left by one, 1 = arithmetic
//   shift right by one with the sign bit preserved.
//   The result is registered, so S is one clock behind D/C.
// PARAMETERS
//   none (width fixed at 32; shift distance fixed at 1)
// PORTS
//   clk    input   1   system clock; all state updates on the rising edge
//   rst_n  input   1   asynchronous reset, active-low
//   C      input   1   direction select: 0 = left, 1 = right (arithmetic)
//   D      input  32   operand, two's complement
//   S      output 32   registered shift result
// BEHAVIOUR
//   - One clock domain: clk. Reset is asynchronous and active-low (rst_n).
//   - Reset: while rst_n=0, S=32'h0000_0000 immediately, with no clock
//     needed. The first capture is on the first rising clk edge after
//     rst_n deasserts.
//   - Combinational next value:
//       C=0: N = {D[30:0], 1'b0}   (MSB D[31] dropped, LSB zero-filled)
//       C=1: N = {D[31], D[31:1]}  (sign replicated, LSB D[0] dropped)
//   - On every rising clk edge with rst_n=1: S <= N.
//   - Latency is 1 cycle. No enable and no handshake: the block accepts a
//     new operand every cycle, throughput 1/cycle.
//   - Left shift has no overflow detection. A sign change (D[31]!=D[30])
//     is silently lost. The block has no flag output.
//   - Right shift of a negative value rounds toward -inf: 32'hFFFF_FFFF
//     -> 32'hFFFF_FFFF. Right shift of 32'h0000_0001 -> 0.
//   - C and D are sampled only at the clock edge. Glitches between edges
//     have no effect on S.
//   - If rst_n is asserted mid-stream, S clears at once and the in-flight
//     result is discarded. After release, S takes the operand captured at
//     the next edge.
//   - No X-propagation guarding: X/Z inputs produce X in the affected bits.
// TESTING
//   1 reset: rst_n=0 with arbitrary D/C -> S=0 without a clock edge;
//     hold through 2 edges -> S stays 0.
//   2 left: C=0, D=32'h9696_9696 -> S=32'h2D2D_2D2C one edge later;
//     C=0, D=32'hE6E6_E6E6 -> S=32'hCDCD_CDCC.
//   3 right negative: C=1, D=32'hBA3A_3A3B -> S=32'hDD1D_1D1D
//     (sign kept); D=32'hFFFF_FFFF -> 32'hFFFF_FFFF.
//   4 right positive: C=1, D=32'h3232_3232 -> S=32'h1919_1919;
//     D=32'h0000_0001 -> 32'h0000_0000.
//   5 back-to-back: change C/D every cycle using the vectors of tests 2-4
//     -> each S matches the prior-cycle inputs. Assert rst_n low
//     mid-stream -> S=0 at once; after release, results resume one edge
//     later.
//   6 edges: C=0, D=32'h8000_0000 -> S=0; C=0, D=32'h4000_0000
//     -> 32'h8000_0000 (overflow, no flag); C=1, D=32'h8000_0000
//     -> 32'hC000_0000.

Source files
------------

// File: rtl/ashifter_32bit.sv
// ashifter_32bit: 32-bit single-position arithmetic shifter, registered output.
//   C = 0 : S <= {D[30:0], 1'b0}   (left, MSB dropped, no overflow flag)
//   C = 1 : S <= {D[31], D[31:1]}  (right, sign replicated, rounds to -inf)
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  async active-low reset, clears S immediately
//   C      in   1  direction select (0 left, 1 right)
//   D      in  32  operand, two's complement
//   S      out 32  shift result, one cycle behind C/D

// One output bit's select: neighbour below for left, neighbour above for right.
module ashifter_bit (
  input  logic sel_i,   // 0 = take left source, 1 = take right source
  input  logic lsrc_i,  // D[i-1] (or zero fill at bit 0)
  input  logic rsrc_i,  // D[i+1] (or sign at bit 31)
  output logic n_o
);
  assign n_o = sel_i ? rsrc_i : lsrc_i;
endmodule

module ashifter_32bit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         C,
  input  logic [W-1:0] D,
  output logic [W-1:0] S
);

  // Neighbour taps with the boundary fills folded in: a zero enters at the
  // bottom on a left shift, the sign bit re-enters at the top on a right shift.
  logic [W:0]   lsrc;   // lsrc[i] feeds bit i on a left shift
  logic [W:0]   rsrc;   // rsrc[i] feeds bit i on a right shift
  logic [W-1:0] s_d;
  logic [W-1:0] s_q;

  assign lsrc = {D, 1'b0};
  assign rsrc = {D[W-1], D[W-1], D[W-1:1]};

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      ashifter_bit u_bit (
        .sel_i  (C),
        .lsrc_i (lsrc[i]),
        .rsrc_i (rsrc[i]),
        .n_o    (s_d[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign S = s_q;

endmodule

// File: tb/tb_ashifter_32bit.sv
module tb_ashifter_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        C = 1'b0;
  logic [31:0] D = 32'h0;
  logic [31:0] S;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ashifter_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .C     (C),
    .D     (D),
    .S     (S)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: left = multiply by two mod 2^32; right = signed floor divide by 2.
  function automatic logic [31:0] model(input logic c, input logic [31:0] d);
    longint v;
    if (!c) return d * 32'd2;
    v = longint'($signed(d));
    if (v < 0) v = (v - 1) / 2;   // floor for negatives
    else       v = v / 2;
    return v[31:0];
  endfunction

  // Drive on the falling edge, expectation goes in the scoreboard.
  task automatic drive(input logic c, input logic [31:0] d);
    @(negedge clk);
    C = c;
    D = d;
    exp_q.push_back(model(c, d));
  endtask

  // Result appears just after the next rising edge.
  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", tag, S);
    end else begin
      chk(tag, S, exp_q.pop_front());
    end
  endtask

  task automatic step(input string tag, input logic c, input logic [31:0] d);
    drive(c, d);
    collect(tag);
  endtask

  typedef struct { logic c; logic [31:0] d; logic [31:0] s; } vec_t;
  vec_t vt[10];

  initial begin
    vt[0] = '{1'b0, 32'h9696_9696, 32'h2D2D_2D2C};
    vt[1] = '{1'b0, 32'hE6E6_E6E6, 32'hCDCD_CDCC};
    vt[2] = '{1'b1, 32'hBA3A_3A3B, 32'hDD1D_1D1D};
    vt[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[4] = '{1'b1, 32'h3232_3232, 32'h1919_1919};
    vt[5] = '{1'b1, 32'h0000_0001, 32'h0000_0000};
    vt[6] = '{1'b0, 32'h8000_0000, 32'h0000_0000};
    vt[7] = '{1'b0, 32'h4000_0000, 32'h8000_0000};
    vt[8] = '{1'b1, 32'h8000_0000, 32'hC000_0000};
    vt[9] = '{1'b0, 32'h0000_0001, 32'h0000_0002};

    // Reset asserted between edges: S must clear without a clock.
    #2;
    C = 1'b1;
    D = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk("rst_async", S, 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", S, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors one at a time, spec constants checked against the model too.
    foreach (vt[k]) begin
      chk("model_sanity", model(vt[k].c, vt[k].d), vt[k].s);
      step($sformatf("dir%0d", k), vt[k].c, vt[k].d);
    end

    // Back-to-back: a new operand every cycle, driver and checker overlapped.
    fork
      foreach (vt[k]) drive(vt[k].c, vt[k].d);
      begin
        for (int k = 0; k < 10; k++) collect($sformatf("b2b%0d", k));
      end
    join

    // Mid-stream reset: in-flight result discarded, S cleared at once.
    drive(1'b0, 32'h1234_5678);
    collect("pre_rst");
    drive(1'b1, 32'h8765_4321);
    #2;                         // between edges, operand in flight
    rst_n = 1'b0;
    #1;
    chk("mid_rst", S, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_hold", S, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    C = 1'b1;
    D = 32'hBA3A_3A3B;
    exp_q.push_back(32'hDD1D_1D1D);
    collect("post_rst");

    // Random stream through the model.
    fork
      for (int k = 0; k < 64; k++) drive(1'($urandom_range(0, 1)), $urandom);
      begin
        for (int k = 0; k < 64; k++) collect("rand");
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d want 0 pending", exp_q.size());
    $fatal(1);
  end

endmodule
